uart_tx_frame_fsm: RTL

//  Transmit framing state machine for the UART TX path. It sits between the baud-rate generator and the TX shift register.
//  It sequences each frame: interval -> start -> data bits -> optional parity -> stop bit(s).
//  It drives the one-hot State_o and BitCounter_o that the shift register decodes into the serial line level.
//  Its INTERVAL->STARTBIT condition is the same one the shift register uses to issue its FIFO read.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_tx_frame_fsm.sv | 108 ++++++++++
 2 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART TX path: one-hot frame state codes plus
// bit-order and FIFO-status encodings used by the shift register.
package uart_tx_pkg;

    typedef enum logic [4:0] {
        ST_INTERVAL  = 5'b0_0001,
        ST_STARTBIT  = 5'b0_0010,
        ST_DATABITS  = 5'b0_0100,
        ST_PARITYBIT = 5'b0_1000,
        ST_STOPBIT   = 5'b1_0000
    } tx_state_e;

    localparam logic BIGEND    = 1'b1;
    localparam logic LITTLEEND = 1'b0;
    localparam logic EMPTY     = 1'b1;
    localparam logic NONEMPTY  = 1'b0;

endpackage

// File: rtl/uart_tx_frame_fsm.sv
// UART TX framing FSM: interval -> start -> data -> optional parity -> stop(s),
// advancing only on baud ticks; drives state/bit index for the shift register.
module uart_tx_frame_fsm
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_BaudSig_i,
    input  logic       p_FiFoEmpty_i,
    input  logic       p_TxEn_i,
    input  logic       p_ParityEn_i,
    input  logic       p_TwoStop_i,
    output logic [4:0] State_o,
    output logic [3:0] BitCounter_o,
    output logic       p_TxBusy_o,
    output logic       p_FrameDone_o
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       par_q, par_d;
    logic       two_q, two_d;
    logic       done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INTERVAL;
            cnt_q   <= 4'd0;
            par_q   <= 1'b0;
            two_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            two_q   <= two_d;
            done_q  <= done_d;
        end
    end

    // p_BaudSig_i is a one-clk qualifier, not a handshake: every transition
    // needs it, and p_FrameDone_o is a single-cycle strobe with no back-pressure.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        two_d   = two_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_INTERVAL: begin
                cnt_d = 4'd0;
                if (p_BaudSig_i && !p_FiFoEmpty_i && p_TxEn_i) begin
                    state_d = ST_STARTBIT;
                    par_d   = p_ParityEn_i;
                    two_d   = p_TwoStop_i;
                end
            end
            ST_STARTBIT: begin
                if (p_BaudSig_i) begin
                    state_d = ST_DATABITS;
                    cnt_d   = 4'd0;
                end
            end
            ST_DATABITS: begin
                if (p_BaudSig_i) begin
                    if (cnt_q == LAST_DATA) begin
                        state_d = par_q ? ST_PARITYBIT : ST_STOPBIT;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITYBIT: begin
                if (p_BaudSig_i) begin
                    state_d = ST_STOPBIT;
                    cnt_d   = 4'd0;
                end
            end
            ST_STOPBIT: begin
                if (p_BaudSig_i) begin
                    if (cnt_q == {3'b000, two_q}) begin
                        state_d = ST_INTERVAL;
                        cnt_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            // Corrupted (non-one-hot) state recovers immediately, tick or not.
            default: begin
                state_d = ST_INTERVAL;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign State_o       = state_q;
    assign BitCounter_o  = cnt_q;
    assign p_TxBusy_o    = (state_q != ST_INTERVAL);
    assign p_FrameDone_o = done_q;

endmodule
